trend_monitor: RTL and testbench

- Synthesizable, parametrised successor to the bench-only torque/brake trend checks.
- Snapshots N signed channels (e.g. omega, avg_curr), waits a programmable settle time, then checks each channel against a commanded trend: increase, decrease or hold within tolerance.
- Sits beside eBike in post-synthesis benches and on FPGA builds as a hardware self-check.
- Reports pass/fail per channel through a start/done handshake.

---
 rtl/trend_monitor_pkg.sv | 26 ++
 rtl/trend_cmp.sv | 54 +++++
 rtl/trend_monitor.sv | 139 +++++++++++++
 tb/tb_trend_monitor.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/trend_monitor_pkg.sv
// Package for trend_monitor: mode/state encodings and default constants.
// Shared by trend_monitor (top) and trend_cmp (per-channel comparator).
package trend_monitor_pkg;

  // Commanded trend; MODE_RSVD behaves like MODE_HOLD.
  typedef enum logic [1:0] {
    MODE_INC  = 2'b00,
    MODE_DEC  = 2'b01,
    MODE_HOLD = 2'b10,
    MODE_RSVD = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SNAP   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int unsigned WIDTH_DEF      = 20;
  localparam int unsigned NUM_CH_DEF     = 2;
  localparam int unsigned CNT_W_DEF      = 22;
  localparam int unsigned SETTLE_MAX_DEF = 2000000;

endpackage

// File: rtl/trend_cmp.sv
// trend_cmp: single-channel combinational trend comparator.
// Optional build macro: TREND_MON_STRICT_EN (strict increase/decrease compare).
// Ports:
//   snap_i  WIDTH  signed sample captured before the settle wait
//   cur_i   WIDTH  signed sample at compare time
//   mode_i  2      commanded trend (inc / dec / hold / reserved=hold)
//   tol_i   WIDTH  unsigned tolerance
//   fail_o  1      channel fails the commanded trend
module trend_cmp
  import trend_monitor_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] snap_i,
  input  logic [WIDTH-1:0] cur_i,
  input  mode_t            mode_i,
  input  logic [WIDTH-1:0] tol_i,
  output logic             fail_o
);

  // One extra bit keeps cur - snap exact for any pair of WIDTH-bit inputs.
  logic signed [WIDTH:0] diff;
  logic        [WIDTH:0] mag;
  logic                  hold_fail;
  logic                  inc_fail;
  logic                  dec_fail;
`ifdef TREND_MON_STRICT_EN
  logic signed [WIDTH+1:0] diff_x;
  logic signed [WIDTH+1:0] tol_x;
`endif

  always_comb begin
    diff      = $signed({cur_i[WIDTH-1], cur_i}) - $signed({snap_i[WIDTH-1], snap_i});
    // |diff| never exceeds 2^WIDTH - 1, so it fits the unsigned WIDTH+1 result.
    mag       = diff[WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    hold_fail = (mag > {1'b0, tol_i});
`ifdef TREND_MON_STRICT_EN
    // Tolerance is unsigned WIDTH bits; widen both operands to WIDTH+2 signed.
    diff_x    = {diff[WIDTH], diff};
    tol_x     = $signed({2'b00, tol_i});
    inc_fail  = !(diff_x > tol_x);
    dec_fail  = !(diff_x < -tol_x);
`else
    inc_fail  = diff[WIDTH];
    dec_fail  = !diff[WIDTH] && (diff != '0);
`endif
    case (mode_i)
      MODE_INC: fail_o = inc_fail;
      MODE_DEC: fail_o = dec_fail;
      default:  fail_o = hold_fail;
    endcase
  end

endmodule

// File: rtl/trend_monitor.sv
// trend_monitor: snapshots NUM_CH signed channels, waits a programmable settle
// time, then checks each channel against a commanded trend.
// Optional build macro: TREND_MON_STRICT_EN (handled inside trend_cmp).
// Ports:
//   clk        1             system clock
//   RST_n      1             asynchronous active-low reset
//   start      1             begins a check when idle
//   mode       2             00 inc, 01 dec, 10 hold, 11 hold
//   settle     CNT_W         wait cycles between snapshot and compare
//   tol        WIDTH         unsigned tolerance
//   samples    NUM_CH*WIDTH  packed signed channels, channel 0 in the LSBs
//   ch_en      NUM_CH        channel enable; disabled channels pass
//   busy       1             check in progress
//   done       1             one-cycle result-valid pulse
//   pass       1             all enabled channels passed
//   fail_mask  NUM_CH        per-channel failure bits
module trend_monitor
  import trend_monitor_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned NUM_CH     = NUM_CH_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned SETTLE_MAX = SETTLE_MAX_DEF
) (
  input  logic                    clk,
  input  logic                    RST_n,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [CNT_W-1:0]        settle,
  input  logic [WIDTH-1:0]        tol,
  input  logic [NUM_CH*WIDTH-1:0] samples,
  input  logic [NUM_CH-1:0]       ch_en,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [NUM_CH-1:0]       fail_mask
);

  state_t                         state_q, state_d;
  logic   [CNT_W-1:0]             cnt_q, cnt_d;
  logic   [CNT_W-1:0]             settle_q;
  logic   [CNT_W-1:0]             settle_clamped;
  mode_t                          mode_q;
  logic   [WIDTH-1:0]             tol_q;
  logic   [NUM_CH-1:0]            ch_en_q;
  logic   [NUM_CH-1:0][WIDTH-1:0] snap_q;
  logic   [NUM_CH-1:0]            fail_mask_q;
  logic                           pass_q;
  logic                           done_q;
  logic   [NUM_CH-1:0]            cmp_fail;
  logic                           accept;

  // A start arriving alongside the done pulse is dropped; the next start
  // must come once the result has been presented.
  assign accept = start && !done_q;

  assign settle_clamped = (settle > CNT_W'(SETTLE_MAX)) ? CNT_W'(SETTLE_MAX) : settle;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_SNAP;
      end
      ST_SNAP: begin
        cnt_d   = settle_q;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_CHECK;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_CHECK: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      settle_q    <= '0;
      mode_q      <= MODE_INC;
      tol_q       <= '0;
      ch_en_q     <= '0;
      snap_q      <= '0;
      fail_mask_q <= '0;
      pass_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            mode_q      <= mode_t'(mode);
            tol_q       <= tol;
            ch_en_q     <= ch_en;
            settle_q    <= settle_clamped;
            pass_q      <= 1'b0;
            fail_mask_q <= '0;
          end
        end
        ST_SNAP: begin
          for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            snap_q[ch] <= samples[ch*WIDTH +: WIDTH];
          end
        end
        ST_CHECK: fail_mask_q <= cmp_fail & ch_en_q;
        ST_DONE: begin
          done_q <= 1'b1;
          pass_q <= ~|(fail_mask_q & ch_en_q);
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cmp
    trend_cmp #(
      .WIDTH(WIDTH)
    ) u_cmp (
      .snap_i(snap_q[g]),
      .cur_i (samples[g*WIDTH +: WIDTH]),
      .mode_i(mode_q),
      .tol_i (tol_q),
      .fail_o(cmp_fail[g])
    );
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_trend_monitor.sv
module tb_trend_monitor;

  localparam int W    = 20;
  localparam int N    = 2;
  localparam int CW   = 22;
  localparam int SMAX = 150;

  logic              clk = 1'b0;
  logic              RST_n;
  logic              start;
  logic [1:0]        mode;
  logic [CW-1:0]     settle;
  logic [W-1:0]      tol;
  logic [N*W-1:0]    samples;
  logic [N-1:0]      ch_en;
  logic              busy;
  logic              done;
  logic              pass;
  logic [N-1:0]      fail_mask;

  trend_monitor #(
    .WIDTH     (W),
    .NUM_CH    (N),
    .CNT_W     (CW),
    .SETTLE_MAX(SMAX)
  ) dut (
    .clk      (clk),
    .RST_n    (RST_n),
    .start    (start),
    .mode     (mode),
    .settle   (settle),
    .tol      (tol),
    .samples  (samples),
    .ch_en    (ch_en),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail_mask(fail_mask)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       pass;
    logic [1:0] fm;
    int         t_start;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (RST_n === 1'b1 && done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("pass", pass, e.pass);
          chk("fail_mask", fail_mask, e.fm);
          chk("latency", cyc - e.t_start, e.lat);
        end
      end
    end
  end

  task automatic wait_done(input int bound);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < bound; k++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("done_seen", seen, 1);
  endtask

  // Issues one check: ch0/ch1 start at a0/b0, move to a1/b1 after the snapshot.
  task automatic run(input logic [1:0] m, input int s, input int t, input logic [1:0] en,
                     input int a0, input int b0, input int a1, input int b1,
                     input logic ep, input logic [1:0] efm, input bit perturb);
    int s_eff;
    s_eff   = (s > SMAX) ? SMAX : s;
    mode    = m;
    settle  = CW'(s);
    tol     = W'(t);
    ch_en   = en;
    samples = {b0[W-1:0], a0[W-1:0]};
    @(negedge clk);
    start = 1'b1;
    sb.push_back('{ep, efm, cyc + 1, s_eff + 4});
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    if (perturb) begin
      mode   = 2'b01;
      tol    = '1;
      settle = '0;
    end
    @(negedge clk);
    samples = {b1[W-1:0], a1[W-1:0]};
    wait_done(s_eff + 20);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    int ndone;
    RST_n   = 1'b0;
    start   = 1'b0;
    mode    = 2'b00;
    settle  = '0;
    tol     = '0;
    samples = '0;
    ch_en   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail_mask", fail_mask, 0);
    RST_n = 1'b1;
    @(negedge clk);

    run(2'b00, 100, 0, 2'b11, 1000, 200, 1500, 300, 1'b1, 2'b00, 1'b0);
    run(2'b01, 5, 0, 2'b11, 5000, 300, 4000, 350, 1'b0, 2'b10, 1'b0);
    run(2'b10, 3, 10, 2'b11, 100, 100, 110, 111, 1'b0, 2'b10, 1'b0);
    run(2'b10, 3, 10, 2'b01, 100, 100, 110, 111, 1'b1, 2'b00, 1'b0);
`ifdef TREND_MON_STRICT_EN
    run(2'b00, 0, 0, 2'b11, 7, 7, 7, 7, 1'b0, 2'b11, 1'b0);
`else
    run(2'b00, 0, 0, 2'b11, 7, 7, 7, 7, 1'b1, 2'b00, 1'b0);
`endif
    run(2'b01, 2, 0, 2'b11, -524288, 524287, 524287, -524288, 1'b0, 2'b01, 1'b0);
    run(2'b00, 2, 0, 2'b11, -524288, 524287, 524287, -524288, 1'b0, 2'b10, 1'b0);
    run(2'b01, 1, 0, 2'b00, 0, 0, 100, 100, 1'b1, 2'b00, 1'b0);
    run(2'b11, 4, 3, 2'b11, 0, 0, -3, 4, 1'b0, 2'b10, 1'b0);
    run(2'b00, 1000, 0, 2'b11, 1, 1, 2, 2, 1'b1, 2'b00, 1'b0);
    run(2'b00, 10, 0, 2'b11, 10, 20, 30, 40, 1'b1, 2'b00, 1'b1);

    // Start coinciding with the done pulse is dropped.
    mode    = 2'b10;
    settle  = CW'(3);
    tol     = '0;
    ch_en   = 2'b11;
    samples = '0;
    @(negedge clk);
    start = 1'b1;
    sb.push_back('{1'b1, 2'b00, cyc + 1, 7});
    @(negedge clk);
    start = 1'b0;
    wait_done(30);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_on_done_ignored", busy, 0);
    @(negedge clk);

    // Reset in the middle of SETTLE aborts without a done pulse.
    mode    = 2'b00;
    settle  = CW'(50);
    samples = {20'd5, 20'd5};
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    RST_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_fail_mask", fail_mask, 0);
    @(negedge clk);
    RST_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("no_done_after_reset", ndone, 0);

    // Fresh start; a second start while busy must be ignored.
    mode    = 2'b10;
    settle  = CW'(20);
    tol     = W'(5);
    ch_en   = 2'b11;
    samples = {-20'sd7, 20'sd10};
    @(negedge clk);
    start = 1'b1;
    sb.push_back('{1'b1, 2'b00, cyc + 1, 24});
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    samples = {-20'sd7, 20'sd12};
    repeat (3) @(negedge clk);
    mode   = 2'b00;
    settle = '0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_during_check", busy, 1);
    wait_done(40);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("no_extra_done", ndone, 0);
    chk("idle_at_end", busy, 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
